karatsuba_seq_ctrl: RTL and testbench

- Sequenced Karatsuba multiplier for N×N unsigned operands with a 2N-bit product.
- A single shared (N/2+1)×(N/2+1) combinational multiplier is reused over three cycles, computing p, q and t in turn.
- A small FSM schedules those three uses and then performs the combine step.
- Valid/ready handshakes on both sides; it is the area-reduced alternative to the fully parallel multiply block.

---
 rtl/karatsuba_seq_ctrl.sv | 124 ++++++++++++
 tb/tb_karatsuba_seq_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/karatsuba_seq_ctrl.sv
// Sequenced Karatsuba multiplier. One shared (N/2+1)x(N/2+1) multiplier is
// used for p, q and t on three consecutive cycles, then the product is held.
module karatsuba_seq_ctrl #(
  parameter int N = 8
) (
  input  logic           iClk,
  input  logic           iRst,
  input  logic           iValid,
  output logic           oReady,
  input  logic [N-1:0]   iX,
  input  logic [N-1:0]   iY,
  output logic           oValid,
  input  logic           iReady,
  output logic [2*N-1:0] oO,
  output logic           oBusy
);

  localparam int H = N / 2;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_MUL_P = 3'd1,
    S_MUL_Q = 3'd2,
    S_MUL_T = 3'd3,
    S_OUT   = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [H-1:0]     r_xh, r_xl, r_yh, r_yl;
  logic [N-1:0]     r_p, r_q;
  logic [2*N-1:0]   r_o;
  logic             r_valid;
  logic [H:0]       w_a, w_b;
  logic [N+1:0]     w_prod;
  logic [N+1:0]     w_m;
  logic [2*N-1:0]   w_combine;

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (iValid) w_next = S_MUL_P; else w_next = S_IDLE;
      S_MUL_P: w_next = S_MUL_Q;
      S_MUL_Q: w_next = S_MUL_T;
      S_MUL_T: w_next = S_OUT;
      S_OUT:   if (iReady) w_next = S_IDLE; else w_next = S_OUT;
      default: w_next = S_IDLE;
    endcase
  end

  // Shared multiplier operand mux; high halves outside the MUL_Q/MUL_T slots
  always_comb begin
    w_a = {1'b0, r_xh};
    w_b = {1'b0, r_yh};
    case (r_state)
      S_MUL_Q: begin
        w_a = {1'b0, r_xl};
        w_b = {1'b0, r_yl};
      end
      S_MUL_T: begin
        w_a = {1'b0, r_xh} + {1'b0, r_xl};
        w_b = {1'b0, r_yh} + {1'b0, r_yl};
      end
      default: begin
        w_a = {1'b0, r_xh};
        w_b = {1'b0, r_yh};
      end
    endcase
  end

  assign w_prod    = {{(H+1){1'b0}}, w_a} * {{(H+1){1'b0}}, w_b};
  // In MUL_T w_prod is t, so w_m = t - p - q (always non-negative)
  assign w_m       = w_prod - {2'b00, r_p} - {2'b00, r_q};
  assign w_combine = {r_p, {N{1'b0}}}
                   + ({{(N-2){1'b0}}, w_m} << H)
                   + {{N{1'b0}}, r_q};

  // State, operand, partial-product and result registers
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_state <= S_IDLE;
      r_xh    <= {H{1'b0}};
      r_xl    <= {H{1'b0}};
      r_yh    <= {H{1'b0}};
      r_yl    <= {H{1'b0}};
      r_p     <= {N{1'b0}};
      r_q     <= {N{1'b0}};
      r_o     <= {(2*N){1'b0}};
      r_valid <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (iValid) begin
            r_xh <= iX[N-1:H];
            r_xl <= iX[H-1:0];
            r_yh <= iY[N-1:H];
            r_yl <= iY[H-1:0];
          end else begin
            r_xh <= r_xh;
          end
        end
        S_MUL_P: r_p <= w_prod[N-1:0];
        S_MUL_Q: r_q <= w_prod[N-1:0];
        S_MUL_T: begin
          r_o     <= w_combine;
          r_valid <= 1'b1;
        end
        S_OUT: begin
          if (iReady) r_valid <= 1'b0;
          else        r_valid <= 1'b1;
        end
        default: r_valid <= 1'b0;
      endcase
    end
  end

  assign oReady = (r_state == S_IDLE);
  assign oBusy  = (r_state != S_IDLE);
  assign oValid = r_valid;
  assign oO     = r_o;

endmodule

// File: tb/tb_karatsuba_seq_ctrl.sv
// Bench for karatsuba_seq_ctrl at N=8 and N=16: a phase-count model of the
// handshake plus plain X*Y products, checked every cycle, with literal pins.
module tb_karatsuba_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_i [2];
  logic        ready_i [2];
  logic [15:0] x_i [2];
  logic [15:0] y_i [2];
  logic        rdy_o [2];
  logic        val_o [2];
  logic        busy_o [2];
  logic [15:0] o8;
  logic [31:0] o16;
  logic [31:0] o_o [2];

  int          checks = 0;
  int          errors = 0;

  int          m_ph [2];
  logic [31:0] m_res [2];
  logic [31:0] m_last [2];

  always #5 clk = ~clk;

  assign o_o[0] = {16'h0000, o8};
  assign o_o[1] = o16;

  karatsuba_seq_ctrl #(.N(8)) dut8 (
    .iClk(clk), .iRst(rst), .iValid(valid_i[0]), .oReady(rdy_o[0]),
    .iX(x_i[0][7:0]), .iY(y_i[0][7:0]), .oValid(val_o[0]), .iReady(ready_i[0]),
    .oO(o8), .oBusy(busy_o[0])
  );

  karatsuba_seq_ctrl #(.N(16)) dut16 (
    .iClk(clk), .iRst(rst), .iValid(valid_i[1]), .oReady(rdy_o[1]),
    .iX(x_i[1]), .iY(y_i[1]), .oValid(val_o[1]), .iReady(ready_i[1]),
    .oO(o16), .oBusy(busy_o[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: phase 0 idle, 1..3 computing, 4 result presented
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        m_ph[k]   <= 0;
        m_res[k]  <= 32'h0;
        m_last[k] <= 32'h0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        case (m_ph[k])
          0: if (valid_i[k]) begin
               m_ph[k]  <= 1;
               m_res[k] <= x_i[k] * y_i[k];
             end
          1, 2: m_ph[k] <= m_ph[k] + 1;
          3: begin
               m_ph[k]   <= 4;
               m_last[k] <= m_res[k];
             end
          4: if (ready_i[k]) m_ph[k] <= 0;
          default: m_ph[k] <= 0;
        endcase
      end
    end
  end

  // Every-cycle compare of both DUTs against the model
  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("oReady[%0d]", k), {31'h0, rdy_o[k]},  {31'h0, m_ph[k] == 0});
        chk($sformatf("oBusy[%0d]", k),  {31'h0, busy_o[k]}, {31'h0, m_ph[k] != 0});
        chk($sformatf("oValid[%0d]", k), {31'h0, val_o[k]},  {31'h0, m_ph[k] == 4});
        chk($sformatf("oO[%0d]", k),     o_o[k],             m_last[k]);
      end
    end
  end

  task automatic wait_idle(input int k);
    int n = 0;
    while (!rdy_o[k] && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk("idle_timeout", {31'h0, rdy_o[k]}, 32'h1);
  endtask

  // One request; stall = cycles of iReady low in OUT; exp = hand value
  task automatic run(input int k, input logic [15:0] x, input logic [15:0] y,
                     input int stall, input logic [31:0] exp, input string name);
    int lat;
    wait_idle(k);
    ready_i[k] = (stall == 0);
    x_i[k] = x; y_i[k] = y; valid_i[k] = 1'b1;
    @(posedge clk); #1;
    valid_i[k] = 1'b0;
    lat = 1;
    while (!val_o[k] && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    chk({name, "_latency"}, lat, 32'd4);
    chk({name, "_result"}, o_o[k], exp);
    chk({name, "_model"}, m_last[k], exp);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      chk({name, "_stall_valid"}, {31'h0, val_o[k]}, 32'h1);
      chk({name, "_stall_oO"}, o_o[k], exp);
    end
    ready_i[k] = 1'b1;
    @(posedge clk); #1;
    chk({name, "_post_valid"}, {31'h0, val_o[k]}, 32'h0);
    chk({name, "_post_ready"}, {31'h0, rdy_o[k]}, 32'h1);
    chk({name, "_retain"}, o_o[k], exp);
  endtask

  initial begin
    logic [15:0] rx, ry;
    int n;
    for (int k = 0; k < 2; k++) begin
      valid_i[k] = 1'b0; ready_i[k] = 1'b1; x_i[k] = 16'h0; y_i[k] = 16'h0;
    end
    #1;
    chk("rst_valid", {31'h0, val_o[0]}, 32'h0);
    chk("rst_oO", o_o[0], 32'h0);
    chk("rst_busy", {31'h0, busy_o[0]}, 32'h0);
    #20;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_ready", {31'h0, rdy_o[0]}, 32'h1);

    run(0, 16'h0012, 16'h0034, 0, 32'h000003A8, "x12_y34");
    run(0, 16'h00FF, 16'h00FF, 0, 32'h0000FE01, "xFF_yFF");
    run(0, 16'h0000, 16'h00AB, 0, 32'h00000000, "x00_yAB");
    run(0, 16'h00A5, 16'h003C, 3, 32'h000026AC, "xA5_y3C_stall");

    // iValid held and operands toggled while busy
    wait_idle(0);
    x_i[0] = 16'h005A; y_i[0] = 16'h00C3; valid_i[0] = 1'b1;
    @(posedge clk); #1;
    n = 0;
    while (!val_o[0] && n < 20) begin
      x_i[0] = {8'h00, ~x_i[0][7:0]}; y_i[0] = {8'h00, y_i[0][7:0] + 8'h11};
      chk("toggle_no_accept", {31'h0, rdy_o[0]}, 32'h0);
      @(posedge clk); #1; n++;
    end
    valid_i[0] = 1'b0;
    chk("toggle_result", o_o[0], 32'h0000448E);
    @(posedge clk); #1;
    chk("toggle_idle", {31'h0, rdy_o[0]}, 32'h1);

    // Reset during MUL_Q
    x_i[0] = 16'h0077; y_i[0] = 16'h0088; valid_i[0] = 1'b1;
    @(posedge clk); #1;
    valid_i[0] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1; #1;
    chk("midrst_valid", {31'h0, val_o[0]}, 32'h0);
    chk("midrst_oO", o_o[0], 32'h0);
    chk("midrst_busy", {31'h0, busy_o[0]}, 32'h0);
    chk("midrst_ready", {31'h0, rdy_o[0]}, 32'h1);
    #1 rst = 1'b0;
    run(0, 16'h0003, 16'h0005, 0, 32'h0000000F, "x03_y05");

    run(1, 16'hFFFF, 16'hFFFF, 0, 32'hFFFE0001, "n16_max");
    for (int i = 0; i < 1000; i++) begin
      rx = 16'($urandom);
      ry = 16'($urandom);
      run(1, rx, ry, int'($urandom_range(0, 1)), rx * ry, "n16_rand");
    end

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
